// File: rtl/conv_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// conv_frame_ctrl_if
//   Bundles the pixel-stream handshake, the coefficient config port and the
//   datapath/result side-band signals of the 3x3 convolution sequencer.
//   master : pixel source / config host / result consumer
//   slave  : conv_frame_ctrl
// Signals
//   s_valid/s_sof/s_eol  pixel qualifiers        s_ready  pixel accepted
//   cfg_we/addr/data     shadow coefficient write cfg_commit arm bank swap
//   ke                   active kernel, coef i at [i*KDW +: KDW]
//   conv_ce              datapath enable          win_valid full window now
//   m_valid/m_sof/m_eol  result qualifiers (re-timed by the datapath latency)
//   frame_done           last result of frame     busy / err  status
// ---------------------------------------------------------------------------
interface conv_frame_ctrl_if #(
    parameter int KDW = 10,
    parameter int KW  = 3
);
    localparam int NU = KW * KW;
    localparam int AW = (NU > 1) ? $clog2(NU) : 1;

    logic              s_valid;
    logic              s_sof;
    logic              s_eol;
    logic              s_ready;
    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [KDW-1:0]    cfg_data;
    logic              cfg_commit;
    logic [KDW*NU-1:0] ke;
    logic              conv_ce;
    logic              win_valid;
    logic              m_valid;
    logic              m_sof;
    logic              m_eol;
    logic              frame_done;
    logic              busy;
    logic              err;

    modport master (
        output s_valid, s_sof, s_eol, cfg_we, cfg_addr, cfg_data, cfg_commit,
        input  s_ready, ke, conv_ce, win_valid, m_valid, m_sof, m_eol,
               frame_done, busy, err
    );

    modport slave (
        input  s_valid, s_sof, s_eol, cfg_we, cfg_addr, cfg_data, cfg_commit,
        output s_ready, ke, conv_ce, win_valid, m_valid, m_sof, m_eol,
               frame_done, busy, err
    );
endinterface

// File: rtl/conv_frame_ctrl.sv
// ---------------------------------------------------------------------------
// conv_frame_ctrl
//   Sequencer for a KWxKW convolution datapath with fixed latency LAT.
//   Tracks row/col of a raster pixel stream, flags pixels that complete a
//   full window, re-times window valid/sof/eol by LAT so they line up with
//   the datapath result, and holds the kernel in a shadow/active bank pair
//   that only swaps at an accepted start-of-frame.
// Ports
//   clk   clock
//   rst   synchronous reset, active-high
//   bus   conv_frame_ctrl_if.slave (stream, config, result side-band)
// ---------------------------------------------------------------------------
module conv_frame_ctrl #(
    parameter int KDW   = 10,
    parameter int KW    = 3,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int LAT   = 8
) (
    input  logic             clk,
    input  logic             rst,
    conv_frame_ctrl_if.slave bus
);
    localparam int NU = KW * KW;
    localparam int AW = (NU > 1) ? $clog2(NU) : 1;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(KW - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(KW - 1);
    localparam logic [LW-1:0] CNT_LAST = LW'(LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] col_reg, col_next, cur_col;
    logic [RW-1:0] row_reg, row_next, cur_row;
    logic [LW-1:0] cnt_reg, cnt_next;
    logic          err_reg, err_next;
    logic          commit_reg, commit_next;

    logic ready, accept, pix, start, swap;
    logic col_end, row_end, line_end;
    logic win, wsof, weol, wlast;
    logic busy;

    // Delay line entry: {last-of-frame, eol, sof, valid}
    logic [3:0] dly_reg [LAT];

    logic [KDW*NU-1:0] ke_flat;

    // -----------------------------------------------------------------------
    // Next-state / counter logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        cur_col    = col_reg;
        cur_row    = row_reg;
        pix        = 1'b0;
        start      = 1'b0;

        // Holding ready low during reset keeps every output at zero then.
        ready  = !rst && (state_reg != FLUSH);
        accept = bus.s_valid && ready;

        unique case (state_reg)
            IDLE: begin
                // Pixels before a start-of-frame are dropped.
                if (accept && bus.s_sof) begin
                    pix     = 1'b1;
                    start   = 1'b1;
                    cur_col = '0;
                    cur_row = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    pix = 1'b1;
                    // Unexpected sof restarts the frame at (0,0); results
                    // already in the delay line are left to drain.
                    if (bus.s_sof) begin
                        start    = 1'b1;
                        err_next = 1'b1;
                        cur_col  = '0;
                        cur_row  = '0;
                    end
                end
            end
            FLUSH: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        col_end  = (cur_col == COL_LAST);
        row_end  = (cur_row == ROW_LAST);
        line_end = col_end || bus.s_eol;

        if (pix) begin
            state_next = RUN;
            // eol must coincide exactly with the last column.
            if (col_end != bus.s_eol) begin
                err_next = 1'b1;
            end
            if (line_end) begin
                col_next = '0;
                // Closing the last line (normally or early) ends the frame.
                if (row_end) begin
                    row_next   = '0;
                    state_next = FLUSH;
                    cnt_next   = '0;
                end else begin
                    row_next = cur_row + 1'b1;
                end
            end else begin
                col_next = cur_col + 1'b1;
            end
        end

        win   = pix && (cur_row >= ROW_WIN) && (cur_col >= COL_WIN);
        wsof  = win && (cur_row == ROW_WIN) && (cur_col == COL_WIN);
        weol  = win && col_end;
        wlast = weol && row_end;

        // A commit arriving in the same cycle as the sof still takes effect.
        swap        = start && (commit_reg || bus.cfg_commit);
        commit_next = swap ? 1'b0 : (commit_reg || bus.cfg_commit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            col_reg    <= '0;
            row_reg    <= '0;
            cnt_reg    <= '0;
            err_reg    <= 1'b0;
            commit_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            col_reg    <= col_next;
            row_reg    <= row_next;
            cnt_reg    <= cnt_next;
            err_reg    <= err_next;
            commit_reg <= commit_next;
        end
    end

    // -----------------------------------------------------------------------
    // Result re-timing: free-running shift so results line up with the
    // datapath output regardless of input gaps.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                dly_reg[i] <= '0;
            end
        end else begin
            dly_reg[0] <= {wlast, weol, wsof, win};
            for (int i = 1; i < LAT; i++) begin
                dly_reg[i] <= dly_reg[i-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Coefficient banks. The active copy loads from the shadow value including
    // any write made on the same edge, so write+commit+sof lands together.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NU; gi++) begin : g_coef
            logic [KDW-1:0] shadow_reg;
            logic [KDW-1:0] shadow_next;
            logic [KDW-1:0] ke_reg;

            // Addresses >= NU match no coefficient and are ignored.
            always_comb begin
                shadow_next = shadow_reg;
                if (bus.cfg_we && (bus.cfg_addr == AW'(gi))) begin
                    shadow_next = bus.cfg_data;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_reg <= '0;
                    ke_reg     <= '0;
                end else begin
                    shadow_reg <= shadow_next;
                    if (swap) begin
                        ke_reg <= shadow_next;
                    end
                end
            end

            assign ke_flat[gi*KDW +: KDW] = ke_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign busy           = (state_reg != IDLE);
    assign bus.s_ready    = ready;
    assign bus.busy       = busy;
    assign bus.conv_ce    = busy;
    assign bus.win_valid  = win;
    assign bus.err        = err_reg;
    assign bus.ke         = ke_flat;
    assign bus.m_valid    = dly_reg[LAT-1][0];
    assign bus.m_sof      = dly_reg[LAT-1][1];
    assign bus.m_eol      = dly_reg[LAT-1][2];
    assign bus.frame_done = dly_reg[LAT-1][3] && dly_reg[LAT-1][0];
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_conv_frame_ctrl
//   Self-checking bench for conv_frame_ctrl with an 8x6 image, 3x3 kernel,
//   latency 8. A table of frame scenarios is run in a loop and the result
//   stream is compared against timings derived from the driven pixels;
//   hand-written sequences cover the kernel swap and mid-frame reset.
// ---------------------------------------------------------------------------
module tb_conv_frame_ctrl;
    localparam int KDW   = 10;
    localparam int KW    = 3;
    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int LAT   = 8;
    localparam int NU    = KW * KW;

    logic clk;
    logic rst;
    int   cyc = 0;

    conv_frame_ctrl_if #(.KDW(KDW), .KW(KW)) bus ();

    conv_frame_ctrl #(
        .KDW(KDW), .KW(KW), .IMG_W(IMG_W), .IMG_H(IMG_H), .LAT(LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Observed result stream
    int m_cyc_q[$];
    bit m_sof_q[$];
    bit m_eol_q[$];
    int fd_q[$];
    int ready_low;

    // Expected result stream built from the driven pixels
    int exp_m_q[$];
    bit exp_sof_q[$];
    bit exp_eol_q[$];
    int exp_fd_q[$];
    int win_seen;

    logic              err_exp;
    logic [KDW*NU-1:0] ke_exp;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.m_valid) begin
                m_cyc_q.push_back(cyc);
                m_sof_q.push_back(bus.m_sof);
                m_eol_q.push_back(bus.m_eol);
            end
            if (bus.frame_done) fd_q.push_back(cyc);
            if (!bus.s_ready) ready_low++;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic clear_q();
        m_cyc_q.delete(); m_sof_q.delete(); m_eol_q.delete(); fd_q.delete();
        exp_m_q.delete(); exp_sof_q.delete(); exp_eol_q.delete(); exp_fd_q.delete();
        ready_low = 0;
        win_seen  = 0;
    endtask

    task automatic idle_inputs();
        bus.s_valid = 1'b0; bus.s_sof = 1'b0; bus.s_eol = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.cfg_commit = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_outputs", {bus.s_ready, bus.ke, bus.conv_ce, bus.win_valid, bus.m_valid,
                                bus.m_sof, bus.m_eol, bus.frame_done, bus.busy, bus.err}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", bus.s_ready, 1'b1);
        @(posedge clk); #1;
        err_exp = 1'b0;
        ke_exp  = '0;
        clear_q();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("win_when_idle", bus.win_valid, 1'b0);
            @(posedge clk); #1;
        end
    endtask

    // Offer one pixel, holding it until accepted (bounded).
    task automatic offer(input bit sof, input bit eol, input bit exp_win, output bit ok, output int ac);
        int waits;
        waits = 0; ok = 1'b0; ac = 0;
        bus.s_valid = 1'b1; bus.s_sof = sof; bus.s_eol = eol;
        while (!ok && waits < 30) begin
            @(negedge clk);
            if (bus.s_ready) begin
                ok = 1'b1;
                ac = cyc;
                check("win_valid", bus.win_valid, exp_win);
                check("err", bus.err, err_exp);
                check("ke", bus.ke, ke_exp);
                if (bus.win_valid) win_seen++;
            end else begin
                check("win_while_stalled", bus.win_valid, 1'b0);
                waits++;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL offer_timeout: got s_ready=0 for 30 cycles required acceptance");
        end
        idle_inputs();
    endtask

    task automatic run_frame(input int gap, input int er, input int ec, input bit do_cfg, input int stop_at);
        int k;
        bit ok, e_eol, w;
        int ac;
        k = 0;
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if (k == stop_at) return;
                e_eol = (c == IMG_W - 1) || (r == er && c == ec);
                w     = (r >= KW - 1) && (c >= KW - 1);
                if (do_cfg && k >= 10 && k <= 18) begin
                    bus.cfg_we   = 1'b1;
                    bus.cfg_addr = 4'(k - 10);
                    bus.cfg_data = 10'(k - 9);
                end
                if (do_cfg && k == 20) bus.cfg_commit = 1'b1;
                offer(r == 0 && c == 0, e_eol, w, ok, ac);
                if (!ok) return;
                if (w) begin
                    exp_m_q.push_back(ac + LAT);
                    exp_sof_q.push_back(r == KW - 1 && c == KW - 1);
                    exp_eol_q.push_back(c == IMG_W - 1);
                end
                if (r == IMG_H - 1 && c == IMG_W - 1) exp_fd_q.push_back(ac + LAT);
                if (r == er && c == ec) err_exp = 1'b1;
                k++;
                if (gap != 0) idle(gap);
                if (e_eol) break;
            end
        end
    endtask

    typedef struct {
        string name;
        int    gap;
        int    er;
        int    ec;
        int    frames;
        bit    cfg;
        int    n_m;
        int    n_sof;
        int    n_eol;
        int    n_fd;
        bit    err;
        int    rl;
    } scen_t;

    scen_t tbl[5];
    logic [KDW*NU-1:0] kexp;
    int n_sof_seen, n_eol_seen;

    initial begin
        rst = 1'b1;
        idle_inputs();
        err_exp = 1'b0;
        ke_exp  = '0;
        clear_q();

        tbl[0] = '{"clean",      0, -1, -1, 1, 1'b0, 24, 1, 4, 1, 1'b0, 8};
        tbl[1] = '{"toggled",    1, -1, -1, 1, 1'b0, 24, 1, 4, 1, 1'b0, 8};
        tbl[2] = '{"early_eol",  0,  2,  5, 1, 1'b0, 22, 1, 3, 1, 1'b1, 8};
        tbl[3] = '{"back2back",  0, -1, -1, 2, 1'b0, 48, 2, 8, 2, 1'b0, 16};
        tbl[4] = '{"cfg_midfrm", 0, -1, -1, 1, 1'b1, 24, 1, 4, 1, 1'b0, 8};

        for (int s = 0; s < 5; s++) begin
            do_reset();
            for (int f = 0; f < tbl[s].frames; f++) begin
                run_frame(tbl[s].gap, tbl[s].er, tbl[s].ec, tbl[s].cfg, -1);
            end
            idle(14);
            check({tbl[s].name, "_win_count"}, win_seen, tbl[s].n_m);
            check({tbl[s].name, "_m_count"}, m_cyc_q.size(), tbl[s].n_m);
            n_sof_seen = 0; n_eol_seen = 0;
            foreach (m_sof_q[i]) if (m_sof_q[i]) n_sof_seen++;
            foreach (m_eol_q[i]) if (m_eol_q[i]) n_eol_seen++;
            check({tbl[s].name, "_m_sof_count"}, n_sof_seen, tbl[s].n_sof);
            check({tbl[s].name, "_m_eol_count"}, n_eol_seen, tbl[s].n_eol);
            for (int i = 0; i < exp_m_q.size(); i++) begin
                if (i < m_cyc_q.size()) begin
                    check({tbl[s].name, "_m_cycle"}, m_cyc_q[i], exp_m_q[i]);
                    check({tbl[s].name, "_m_sof"}, m_sof_q[i], exp_sof_q[i]);
                    check({tbl[s].name, "_m_eol"}, m_eol_q[i], exp_eol_q[i]);
                end
            end
            check({tbl[s].name, "_fd_count"}, fd_q.size(), tbl[s].n_fd);
            for (int i = 0; i < exp_fd_q.size(); i++) begin
                if (i < fd_q.size()) check({tbl[s].name, "_fd_cycle"}, fd_q[i], exp_fd_q[i]);
            end
            @(negedge clk);
            check({tbl[s].name, "_err_final"}, bus.err, tbl[s].err);
            check({tbl[s].name, "_ready_low_cycles"}, ready_low, tbl[s].rl);
            check({tbl[s].name, "_busy_end"}, bus.busy, 1'b0);
            @(posedge clk); #1;
            $display("scenario %s: %0d results, %0d frame_done", tbl[s].name, m_cyc_q.size(), fd_q.size());
        end

        // Kernel swap: commit armed during the last frame, ke moves on next sof.
        for (int i = 0; i < NU; i++) kexp[i*KDW +: KDW] = KDW'(i + 1);
        bus.s_valid = 1'b1; bus.s_sof = 1'b1;
        @(negedge clk);
        check("ke_before_sof", bus.ke, '0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("ke_after_sof", bus.ke, kexp);
        check("conv_ce_in_run", bus.conv_ce, 1'b1);
        @(posedge clk); #1;
        $display("kernel swap: ke=%0h", bus.ke);

        // Write + commit + sof in one cycle; out-of-range address ignored.
        do_reset();
        bus.cfg_we = 1'b1; bus.cfg_addr = 4'd15; bus.cfg_data = 10'd555;
        @(posedge clk); #1;
        bus.cfg_addr = 4'd0; bus.cfg_data = 10'd77; bus.cfg_commit = 1'b1;
        bus.s_valid = 1'b1; bus.s_sof = 1'b1;
        @(negedge clk);
        check("ke_same_cycle_before", bus.ke, '0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        kexp = '0;
        kexp[KDW-1:0] = 10'd77;
        check("ke_same_cycle_after", bus.ke, kexp);
        check("err_same_cycle", bus.err, 1'b0);
        @(posedge clk); #1;
        $display("same-cycle write/commit/sof: ke=%0h", bus.ke);

        // Reset at row 3 col 4 with results in flight.
        do_reset();
        run_frame(0, -1, -1, 1'b0, 3 * IMG_W + 4);
        rst = 1'b1;
        bus.s_valid = 1'b1;
        @(negedge clk);
        check("ready_in_rst", bus.s_ready, 1'b0);
        check("win_in_rst", bus.win_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_q();
        @(negedge clk);
        check("outputs_after_rst", {bus.ke, bus.conv_ce, bus.win_valid, bus.m_valid, bus.m_sof,
                                    bus.m_eol, bus.frame_done, bus.busy, bus.err}, '0);
        check("ready_after_rst", bus.s_ready, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("drop_busy", bus.busy, 1'b0);
            check("drop_win", bus.win_valid, 1'b0);
            @(posedge clk); #1;
        end
        idle_inputs();
        idle(4);
        check("no_results_after_rst", m_cyc_q.size(), 0);
        $display("mid-frame reset: %0d results after reset", m_cyc_q.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
